// File: rtl/if_stage_fetch.sv
// Instruction fetch: owns the PC, drives imem_addr, captures the returned word into IF/ID.
// Latency: imem_addr = pc combinationally; the instruction at pc appears in IF/ID after one edge.
// Backpressure: stall holds pc/IF/ID/count; redirect flushes; an out-of-bounds or misaligned target halts until reset.
module if_stage_fetch #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned IMEM_BYTES = 512,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [63:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [63:0] pc,
   output logic        halted,
   output logic [1:0]  fault_code,
   output logic [31:0] fetch_count
);

   localparam logic [63:0] LAST_ADDR = 64'(IMEM_BYTES - 4);

   localparam logic [1:0] FAULT_NONE  = 2'b00;
   localparam logic [1:0] FAULT_OOB   = 2'b01;
   localparam logic [1:0] FAULT_ALIGN = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state;
   logic [63:0] r_pc;
   logic [63:0] r_if_id_pc;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;
   logic [1:0]  r_fault_code;
   logic [31:0] r_fetch_count;

   state_t      w_state_nxt;
   logic [63:0] w_pc_nxt;
   logic [63:0] w_if_id_pc_nxt;
   logic [31:0] w_if_id_instr_nxt;
   logic        w_if_id_valid_nxt;
   logic [1:0]  w_fault_code_nxt;
   logic [31:0] w_fetch_count_nxt;
   logic        w_oob;
   logic        w_bubble;

   // Memory data is only meaningful while pc addresses a full word inside the array.
   assign w_oob = (r_pc > LAST_ADDR);

   // State and pipeline register update; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_if_id_pc    <= 64'h0;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
         r_fault_code  <= FAULT_NONE;
         r_fetch_count <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_if_id_pc    <= w_if_id_pc_nxt;
         r_if_id_instr <= w_if_id_instr_nxt;
         r_if_id_valid <= w_if_id_valid_nxt;
         r_fault_code  <= w_fault_code_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   // Next-state: in RUN the priority is redirect, then bounds fault, then stall, then normal fetch.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_if_id_pc_nxt    = r_if_id_pc;
      w_if_id_instr_nxt = r_if_id_instr;
      w_if_id_valid_nxt = r_if_id_valid;
      w_fault_code_nxt  = r_fault_code;
      w_fetch_count_nxt = r_fetch_count;
      w_bubble          = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (redirect) begin
               w_bubble = 1'b1;
               if (redirect_pc[1:0] == 2'b00) begin
                  w_pc_nxt = redirect_pc;
               end else begin
                  w_state_nxt      = S_HALT;
                  w_fault_code_nxt = FAULT_ALIGN;
               end
            end else if (w_oob) begin
               w_bubble         = 1'b1;
               w_state_nxt      = S_HALT;
               w_fault_code_nxt = FAULT_OOB;
            end else if (!stall) begin
               w_pc_nxt          = r_pc + 64'd4;
               w_if_id_pc_nxt    = r_pc;
               w_if_id_instr_nxt = imem_instr;
               w_if_id_valid_nxt = 1'b1;
               if (r_fetch_count != 32'hFFFFFFFF) begin
                  w_fetch_count_nxt = r_fetch_count + 32'd1;
               end
            end
         end
         S_HALT: begin
            // Everything holds; only reset leaves HALT.
         end
         default: begin
            w_state_nxt = S_HALT;
            w_bubble    = 1'b1;
         end
      endcase

      // A flush or fault replaces whatever IF/ID would have captured with a bubble.
      if (w_bubble) begin
         w_if_id_pc_nxt    = 64'h0;
         w_if_id_instr_nxt = NOP_INSTR;
         w_if_id_valid_nxt = 1'b0;
      end
   end

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_instr = r_if_id_instr;
   assign if_id_valid = r_if_id_valid;
   assign halted      = (r_state == S_HALT);
   assign fault_code  = r_fault_code;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a combinational instruction memory model.
// Each memory word is 32'hA000_0000 | address, so expected IF/ID contents are easy to hand-derive.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_if_stage_fetch;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [63:0] pc;
   logic        halted;
   logic [1:0]  fault_code;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_errors = 0;

   if_stage_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .pc          (pc),
      .halted      (halted),
      .fault_code  (fault_code),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 512-byte memory; reads past the end return a poison word.
   always_comb begin
      if (imem_addr < 64'd512) imem_instr = 32'hA000_0000 | imem_addr[31:0];
      else                     imem_instr = 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".pc"},    pc,          64'h0);
      check({tag, ".addr"},  imem_addr,   64'h0);
      check({tag, ".idpc"},  if_id_pc,    64'h0);
      check({tag, ".instr"}, {32'h0, if_id_instr}, 64'h13);
      check({tag, ".valid"}, {63'h0, if_id_valid}, 64'h0);
      check({tag, ".halt"},  {63'h0, halted},      64'h0);
      check({tag, ".fault"}, {62'h0, fault_code},  64'h0);
      check({tag, ".cnt"},   {32'h0, fetch_count}, 64'h0);
   endtask

   task automatic check_ifid(input string tag, input logic [63:0] epc, input logic [31:0] ei,
                             input logic [63:0] enext, input logic [31:0] ecnt);
      check({tag, ".idpc"},  if_id_pc,             epc);
      check({tag, ".instr"}, {32'h0, if_id_instr}, {32'h0, ei});
      check({tag, ".valid"}, {63'h0, if_id_valid}, 64'h1);
      check({tag, ".pc"},    pc,                   enext);
      check({tag, ".cnt"},   {32'h0, fetch_count}, {32'h0, ecnt});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
      step();
      check_reset_state("rst");

      // IDLE ignores redirect and stall.
      reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
      step();
      check("idle.pc", pc, 64'h0);
      check("idle.valid", {63'h0, if_id_valid}, 64'h0);
      redirect = 1'b0; stall = 1'b0;

      // Start, then four straight-line fetches.
      start = 1'b1;
      step();
      start = 1'b0;
      check("start.pc", pc, 64'h0);
      step(); check_ifid("f0", 64'h0, 32'hA000_0000, 64'h4,  32'd1);
      step(); check_ifid("f1", 64'h4, 32'hA000_0004, 64'h8,  32'd2);
      step(); check_ifid("f2", 64'h8, 32'hA000_0008, 64'hC,  32'd3);

      // Stall for exactly three cycles holds IF/ID, pc and count.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 64'h8, 32'hA000_0008, 64'hC, 32'd3);
      end
      stall = 1'b0;
      step(); check_ifid("f3", 64'hC, 32'hA000_000C, 64'h10, 32'd4);

      // Redirect wins over a simultaneous stall and flushes IF/ID.
      redirect = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
      step();
      redirect = 1'b0; stall = 1'b0;
      check("redir.pc", pc, 64'h40);
      check("redir.valid", {63'h0, if_id_valid}, 64'h0);
      check("redir.instr", {32'h0, if_id_instr}, 64'h13);
      check("redir.idpc", if_id_pc, 64'h0);
      check("redir.cnt", {32'h0, fetch_count}, 64'd4);
      step(); check_ifid("f40", 64'h40, 32'hA000_0040, 64'h44, 32'd5);

      // Straight-line run: 110 fetches from 0x44 through 0x1F8.
      for (int i = 0; i < 110; i++) step();
      check("run.pc", pc, 64'd508);
      check("run.cnt", {32'h0, fetch_count}, 64'd115);
      step(); check_ifid("f508", 64'd504 + 64'd4, 32'hA000_01FC, 64'd512, 32'd116);

      // pc=512 faults on the next edge.
      step();
      check("oob.halt", {63'h0, halted}, 64'h1);
      check("oob.fault", {62'h0, fault_code}, 64'h1);
      check("oob.valid", {63'h0, if_id_valid}, 64'h0);
      check("oob.instr", {32'h0, if_id_instr}, 64'h13);
      check("oob.pc", pc, 64'd512);
      check("oob.cnt", {32'h0, fetch_count}, 64'd116);

      // HALT ignores start and redirect.
      start = 1'b1;
      step();
      start = 1'b0; redirect = 1'b1; redirect_pc = 64'h80;
      step();
      redirect = 1'b0;
      check("halt.pc", pc, 64'd512);
      check("halt.halt", {63'h0, halted}, 64'h1);
      check("halt.fault", {62'h0, fault_code}, 64'h1);
      check("halt.valid", {63'h0, if_id_valid}, 64'h0);

      // Reset out of HALT.
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_state("rsthalt");

      // Misaligned redirect target.
      start = 1'b1;
      step();
      start = 1'b0;
      step(); check_ifid("m0", 64'h0, 32'hA000_0000, 64'h4, 32'd1);
      redirect = 1'b1; redirect_pc = 64'h42;
      step();
      redirect = 1'b0;
      check("mis.halt", {63'h0, halted}, 64'h1);
      check("mis.fault", {62'h0, fault_code}, 64'h2);
      check("mis.pc", pc, 64'h4);
      check("mis.valid", {63'h0, if_id_valid}, 64'h0);
      check("mis.instr", {32'h0, if_id_instr}, 64'h13);
      check("mis.idpc", if_id_pc, 64'h0);

      // Reset while stalled in RUN.
      reset = 1'b1;
      step();
      reset = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); check_ifid("s0", 64'h0, 32'hA000_0000, 64'h4, 32'd1);
      stall = 1'b1;
      step(); check_ifid("s1", 64'h0, 32'hA000_0000, 64'h4, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0;
      check_reset_state("rststall");

      // Still IDLE without start.
      step();
      check("post.pc", pc, 64'h0);
      check("post.valid", {63'h0, if_id_valid}, 64'h0);
      check("post.cnt", {32'h0, fetch_count}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
